// File: rtl/timer_pkg.sv
// Shared constants for the 16-bit timer peripheral: register offsets, control and
// status bit positions, and the address region used by the system decoder.
package timer_pkg;

   localparam int WIDTH = 16;

   localparam logic [3:0] TIMER_REGION = 4'hA;

   typedef enum logic [3:0] {
      OFS_CTRL     = 4'h0,
      OFS_PRESCALE = 4'h1,
      OFS_COUNT    = 4'h2,
      OFS_COMPARE  = 4'h3,
      OFS_STATUS   = 4'h4
   } reg_ofs_e;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_AUTO   = 1;
   localparam int CTRL_IRQ_EN = 2;

   localparam int STAT_MATCH = 0;
   localparam int STAT_OVF   = 1;

endpackage

// File: rtl/timer_prescaler.sv
// Divides the enabled clock down to one tick every (period + 1) cycles; the phase
// counter restarts whenever the timer is disabled or software rewrites the period.
module timer_prescaler
   import timer_pkg::*;
#(
   parameter int PWIDTH = WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [PWIDTH-1:0] period,
   input  logic              clear,
   output logic              tick
);

   logic [PWIDTH-1:0] pcnt;

   assign tick = en && (pcnt == period);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt <= '0;
      end else if (!en || clear || tick) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + 1'b1;
      end
   end

endmodule

// File: rtl/timer_periph.sv
// Memory-mapped prescaled up-counter with compare match, one-shot or auto-reload
// operation, sticky write-one-to-clear status flags and a level interrupt.
module timer_periph
   import timer_pkg::*;
#(
   parameter int               DWIDTH       = WIDTH,
   parameter logic [DWIDTH-1:0] RST_PRESCALE = 16'h0000,
   parameter logic [DWIDTH-1:0] RST_COMPARE  = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       timer_addr,
   input  logic [DWIDTH-1:0] timer_wdata,
   input  logic              timer_we,
   output logic [DWIDTH-1:0] timer_rdata,
   output logic              timer_irq
);

   logic [2:0]        ctrl;
   logic [DWIDTH-1:0] prescale;
   logic [DWIDTH-1:0] count;
   logic [DWIDTH-1:0] compare;
   logic [1:0]        status;

   logic [3:0] ofs;
   logic       unused_addr_hi;
   logic       wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
   logic       tick, tick_live, at_match;
   logic       set_match, set_ovf, one_shot_stop;

   assign ofs            = timer_addr[3:0];
   assign unused_addr_hi = ^timer_addr[15:4];

   assign wr_ctrl     = timer_we && (ofs == OFS_CTRL);
   assign wr_prescale = timer_we && (ofs == OFS_PRESCALE);
   assign wr_count    = timer_we && (ofs == OFS_COUNT);
   assign wr_compare  = timer_we && (ofs == OFS_COMPARE);
   assign wr_status   = timer_we && (ofs == OFS_STATUS);

   timer_prescaler #(
      .PWIDTH(DWIDTH)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .en     (ctrl[CTRL_EN]),
      .period (prescale),
      .clear  (wr_prescale),
      .tick   (tick)
   );

   // A software write to COUNT swallows the whole effect of a coincident tick,
   // including the flag it would have raised and any one-shot stop.
   assign tick_live     = tick && !wr_count;
   assign at_match      = (count == compare);
   assign set_match     = tick_live && at_match;
   assign set_ovf       = tick_live && !at_match && (&count);
   assign one_shot_stop = set_match && !ctrl[CTRL_AUTO];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl     <= '0;
         prescale <= RST_PRESCALE;
         count    <= '0;
         compare  <= RST_COMPARE;
         status   <= '0;
      end else begin
         if (wr_ctrl) begin
            ctrl <= timer_wdata[2:0];
         end else if (one_shot_stop) begin
            ctrl[CTRL_EN] <= 1'b0;
         end

         if (wr_prescale) begin
            prescale <= timer_wdata;
         end

         if (wr_compare) begin
            compare <= timer_wdata;
         end

         // The increment wraps 0xFFFF to 0 on its own; overflow only needs the flag.
         if (wr_count) begin
            count <= timer_wdata;
         end else if (tick) begin
            if (at_match) begin
               if (ctrl[CTRL_AUTO]) begin
                  count <= '0;
               end
            end else begin
               count <= count + 1'b1;
            end
         end

         // Hardware set is OR-ed in after the clear so a coincident set survives.
         status <= (wr_status ? (status & ~timer_wdata[1:0]) : status) | {set_ovf, set_match};
      end
   end

   always_comb begin
      timer_rdata = '0;
      case (ofs)
         OFS_CTRL:     timer_rdata = {{(DWIDTH-3){1'b0}}, ctrl};
         OFS_PRESCALE: timer_rdata = prescale;
         OFS_COUNT:    timer_rdata = count;
         OFS_COMPARE:  timer_rdata = compare;
         OFS_STATUS:   timer_rdata = {{(DWIDTH-2){1'b0}}, status};
         default:      timer_rdata = '0;
      endcase
   end

   assign timer_irq = ctrl[CTRL_IRQ_EN] && (|status);

endmodule

// File: tb/tb_timer_periph.sv
// Bench for timer_periph: directed scenarios with literal expectations plus a long
// randomized run, all checked every cycle against a register-level reference model.
module tb_timer_periph;
   import timer_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] timer_addr;
   logic [15:0] timer_wdata;
   logic        timer_we;
   logic [15:0] timer_rdata;
   logic        timer_irq;

   int checks   = 0;
   int failures = 0;
   bit model_on = 1'b0;

   always #5 clk = ~clk;

   timer_periph dut (
      .clk         (clk),
      .rst         (rst),
      .timer_addr  (timer_addr),
      .timer_wdata (timer_wdata),
      .timer_we    (timer_we),
      .timer_rdata (timer_rdata),
      .timer_irq   (timer_irq)
   );

   // Reference state: the programmer-visible registers plus the number of enabled
   // cycles spent so far in the current prescale period.
   logic [2:0]  m_ctrl;
   logic [15:0] m_pre, m_phase, m_count, m_cmp;
   logic [1:0]  m_status;

   logic [3:0]  s_ofs;
   logic        s_wr, s_tick, s_stop;
   logic [1:0]  s_set;
   logic [15:0] s_next;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ctrl   = 3'b000;
         m_pre    = 16'h0000;
         m_phase  = 16'h0000;
         m_count  = 16'h0000;
         m_cmp    = 16'hFFFF;
         m_status = 2'b00;
      end else begin
         s_ofs  = timer_addr[3:0];
         s_wr   = timer_we;
         s_tick = m_ctrl[0] && (m_phase == m_pre);
         s_set  = 2'b00;
         s_stop = 1'b0;
         s_next = m_count;
         if (s_wr && s_ofs == 4'h2) begin
            s_next = timer_wdata;
         end else if (s_tick) begin
            if (m_count == m_cmp) begin
               s_set[0] = 1'b1;
               if (m_ctrl[1]) s_next = 16'h0000;
               else s_stop = 1'b1;
            end else begin
               s_next = 16'((int'(m_count) + 1) % 65536);
               if (m_count == 16'hFFFF) s_set[1] = 1'b1;
            end
         end
         if (!m_ctrl[0] || s_tick || (s_wr && s_ofs == 4'h1)) m_phase = 16'h0000;
         else m_phase = m_phase + 16'h0001;
         m_count = s_next;
         if (s_wr && s_ofs == 4'h0) m_ctrl = timer_wdata[2:0];
         else if (s_stop) m_ctrl[0] = 1'b0;
         if (s_wr && s_ofs == 4'h1) m_pre = timer_wdata;
         if (s_wr && s_ofs == 4'h3) m_cmp = timer_wdata;
         if (s_wr && s_ofs == 4'h4) m_status = m_status & ~timer_wdata[1:0];
         m_status = m_status | s_set;
      end
   end

   function automatic logic [15:0] modelRead(input logic [3:0] ofs);
      case (ofs)
         4'h0:    return {13'b0, m_ctrl};
         4'h1:    return m_pre;
         4'h2:    return m_count;
         4'h3:    return m_cmp;
         4'h4:    return {14'b0, m_status};
         default: return 16'h0000;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_on && !rst) begin
         checkOutput("rdata_vs_model", timer_rdata, modelRead(timer_addr[3:0]));
         checkOutput("irq_vs_model", {15'b0, timer_irq},
                     {15'b0, m_ctrl[2] & (|m_status)});
      end
   end

   task automatic applyStimulus(input logic we, input logic [3:0] ofs, input logic [15:0] data);
      logic [11:0] hi;
      hi          = 12'($urandom);
      timer_we    = we;
      timer_addr  = {hi, ofs};
      timer_wdata = data;
      @(posedge clk);
      #1;
      timer_we = 1'b0;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 4'($urandom_range(0, 7)), 16'($urandom));
   endtask

   task automatic peek(input string name, input logic [3:0] ofs, input logic [15:0] exp);
      timer_addr = {TIMER_REGION, 8'h00, ofs};
      #1;
      checkOutput(name, timer_rdata, exp);
   endtask

   task automatic doReset();
      @(negedge clk);
      #1 rst = 1'b1;
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   logic [15:0] seq2 [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0000};

   initial begin
      rst         = 1'b1;
      timer_we    = 1'b0;
      timer_addr  = 16'h0000;
      timer_wdata = 16'h0000;
      #12 rst = 1'b0;
      model_on = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] reset values");
      peek("rst_ctrl", 4'h0, 16'h0000);
      peek("rst_prescale", 4'h1, 16'h0000);
      peek("rst_count", 4'h2, 16'h0000);
      peek("rst_compare", 4'h3, 16'hFFFF);
      peek("rst_status", 4'h4, 16'h0000);
      peek("rst_unmapped", 4'h7, 16'h0000);
      checkOutput("rst_irq", {15'b0, timer_irq}, 16'h0000);

      $display("[TB] auto-reload match");
      applyStimulus(1'b1, OFS_PRESCALE, 16'h0000);
      applyStimulus(1'b1, OFS_COMPARE, 16'h0003);
      applyStimulus(1'b1, OFS_CTRL, 16'h0007);
      for (int i = 0; i < 4; i++) begin
         idle();
         peek("auto_count", 4'h2, seq2[i]);
         peek("auto_status", 4'h4, (i == 3) ? 16'h0001 : 16'h0000);
      end
      checkOutput("auto_irq", {15'b0, timer_irq}, 16'h0001);

      $display("[TB] one-shot with prescale");
      doReset();
      applyStimulus(1'b1, OFS_PRESCALE, 16'h0002);
      applyStimulus(1'b1, OFS_COMPARE, 16'h0001);
      applyStimulus(1'b1, OFS_CTRL, 16'h0001);
      for (int i = 1; i <= 6; i++) begin
         idle();
         peek("oneshot_status", 4'h4, (i == 6) ? 16'h0001 : 16'h0000);
      end
      peek("oneshot_count", 4'h2, 16'h0001);
      peek("oneshot_ctrl", 4'h0, 16'h0000);
      repeat (3) idle();
      peek("oneshot_hold", 4'h2, 16'h0001);

      $display("[TB] overflow and W1C");
      doReset();
      applyStimulus(1'b1, OFS_COUNT, 16'hFFFE);
      applyStimulus(1'b1, OFS_COMPARE, 16'h0005);
      applyStimulus(1'b1, OFS_PRESCALE, 16'h0000);
      applyStimulus(1'b1, OFS_CTRL, 16'h0005);
      idle();
      idle();
      peek("ovf_count", 4'h2, 16'h0000);
      peek("ovf_status", 4'h4, 16'h0002);
      checkOutput("ovf_irq", {15'b0, timer_irq}, 16'h0001);
      applyStimulus(1'b1, OFS_STATUS, 16'h0002);
      peek("ovf_cleared", 4'h4, 16'h0000);
      checkOutput("ovf_irq_clr", {15'b0, timer_irq}, 16'h0000);

      $display("[TB] set wins over W1C");
      doReset();
      applyStimulus(1'b1, OFS_PRESCALE, 16'h0000);
      applyStimulus(1'b1, OFS_COMPARE, 16'h0002);
      applyStimulus(1'b1, OFS_CTRL, 16'h0003);
      repeat (5) idle();
      peek("w1c_pre_count", 4'h2, 16'h0002);
      applyStimulus(1'b1, OFS_STATUS, 16'h0001);
      peek("w1c_collide", 4'h4, 16'h0001);
      peek("w1c_count", 4'h2, 16'h0000);
      applyStimulus(1'b1, OFS_STATUS, 16'h0001);
      peek("w1c_clear", 4'h4, 16'h0000);

      $display("[TB] async reset mid-count");
      doReset();
      applyStimulus(1'b1, OFS_COUNT, 16'h0042);
      applyStimulus(1'b1, OFS_COMPARE, 16'h0042);
      applyStimulus(1'b1, OFS_CTRL, 16'h0007);
      idle();
      checkOutput("mid_irq_before", {15'b0, timer_irq}, 16'h0001);
      rst = 1'b1;
      #1;
      checkOutput("mid_irq_async", {15'b0, timer_irq}, 16'h0000);
      peek("mid_ctrl", 4'h0, 16'h0000);
      peek("mid_count", 4'h2, 16'h0000);
      peek("mid_compare", 4'h3, 16'hFFFF);
      peek("mid_status", 4'h4, 16'h0000);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] randomized traffic");
      for (int n = 0; n < 4000; n++) begin
         logic        we;
         logic [3:0]  ofs;
         logic [15:0] data;
         we   = ($urandom_range(0, 3) == 0);
         ofs  = 4'($urandom_range(0, 7));
         data = 16'($urandom);
         case (ofs)
            4'h0: data[0] = ($urandom_range(0, 3) != 0);
            4'h1: data = 16'($urandom_range(0, 3));
            4'h2: data = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 12))
                                                     : 16'(16'hFFF0 + $urandom_range(0, 15));
            4'h3: data = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 12));
            default: ;
         endcase
         applyStimulus(we, ofs, data);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
